// File: rtl/gumnut_port_pkg.sv
// rtl/gumnut_port_pkg.sv - shared constants and types for Gumnut port-bus peripherals
//
// Register offsets within an 8-port window, CTRL/STATUS bit positions,
// the CTRL register layout, and a helper for forming absolute port
// addresses from a window base and an offset.
package gumnut_port_pkg;

  localparam logic [2:0] OFS_CTRL     = 3'd0;
  localparam logic [2:0] OFS_STATUS   = 3'd1;
  localparam logic [2:0] OFS_RELOAD   = 3'd2;
  localparam logic [2:0] OFS_COUNT    = 3'd3;
  localparam logic [2:0] OFS_PRESCALE = 3'd4;

  localparam int CTRL_EN_BIT    = 0;
  localparam int CTRL_IE_BIT    = 1;
  localparam int CTRL_AUTO_BIT  = 2;
  localparam int STATUS_EXP_BIT = 0;

  // Packed so that bit 0 is EN, bit 1 is IE and bit 2 is AUTO.
  typedef struct packed {
    logic auto_mode;
    logic ie;
    logic en;
  } ctrl_t;

  function automatic logic [7:0] reg_addr(input logic [7:0] base, input logic [2:0] ofs);
    return base + {5'd0, ofs};
  endfunction

endpackage

// File: rtl/gumnut_prescaler.sv
// rtl/gumnut_prescaler.sv - 8-bit down-counting clock prescaler with restart
//
// Ports:
//   clk_i      system clock
//   rst_ni     asynchronous active-low reset
//   en_i       count while high, hold while low
//   restart_i  reload the counter from divisor_i
//   divisor_i  tick period minus one
//   tick_o     one-cycle pulse every divisor_i+1 enabled clocks
module gumnut_prescaler (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       en_i,
  input  logic       restart_i,
  input  logic [7:0] divisor_i,
  output logic       tick_o
);

  logic [7:0] cnt_q;

  // The tick is emitted in the cycle the counter sits at zero; the wrap
  // back to the divisor happens on the same edge that consumes the tick.
  assign tick_o = en_i & (cnt_q == 8'd0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= 8'd0;
    end else if (restart_i) begin
      cnt_q <= divisor_i;
    end else if (en_i) begin
      if (cnt_q == 8'd0) cnt_q <= divisor_i;
      else               cnt_q <= cnt_q - 8'd1;
    end
  end

endmodule

// File: rtl/gumnut_port_timer.sv
// rtl/gumnut_port_timer.sv - programmable interval timer on the Gumnut port bus
//
// Ports:
//   clk_i       system clock
//   rst_ni      asynchronous active-low reset
//   port_cyc_i  bus cycle active
//   port_stb_i  transfer strobe
//   port_we_i   1 = write, 0 = read
//   port_adr_i  port address
//   port_dat_i  write data
//   port_ack_o  registered single-cycle acknowledge
//   port_dat_o  read data, zero whenever port_ack_o is low
//   int_req_o   interrupt request (EXP & IE)
//   int_ack_i   interrupt taken pulse from the core
module gumnut_port_timer
  import gumnut_port_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR = 8'h10
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       port_cyc_i,
  input  logic       port_stb_i,
  input  logic       port_we_i,
  input  logic [7:0] port_adr_i,
  input  logic [7:0] port_dat_i,
  output logic       port_ack_o,
  output logic [7:0] port_dat_o,
  output logic       int_req_o,
  input  logic       int_ack_i
);

  ctrl_t      ctrl_q;
  logic       exp_q;
  logic [7:0] reload_q;
  logic [7:0] count_q;
  logic [7:0] prescale_q;
  logic       xfer_hold_q;

  logic       cyc_stb;
  logic       req;
  logic       wr;
  logic       rd;
  logic [2:0] ofs;
  logic       wr_ctrl;
  logic       wr_status;
  logic       wr_reload;
  logic       wr_prescale;
  logic       tick;
  logic       restart;
  logic       expire;
  logic       exp_clr;
  logic [7:0] rdata;

  assign cyc_stb = port_cyc_i & port_stb_i;
  assign ofs     = port_adr_i[2:0];

  // xfer_hold_q stays set while the same strobe is held after its ack, so a
  // master that keeps the strobe up gets exactly one acknowledge.
  assign req = cyc_stb & (port_adr_i[7:3] == BASE_ADDR[7:3]) & ~xfer_hold_q & ~port_ack_o;
  assign wr  = req & port_we_i;
  assign rd  = req & ~port_we_i;

  assign wr_ctrl     = wr & (ofs == OFS_CTRL);
  assign wr_status   = wr & (ofs == OFS_STATUS);
  assign wr_reload   = wr & (ofs == OFS_RELOAD);
  assign wr_prescale = wr & (ofs == OFS_PRESCALE);

  // Restart on any RELOAD write, and on a CTRL write that turns EN on.
  assign restart = wr_reload | (wr_ctrl & port_dat_i[CTRL_EN_BIT] & ~ctrl_q.en);

  gumnut_prescaler u_prescaler (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .en_i      (ctrl_q.en),
    .restart_i (restart),
    .divisor_i (prescale_q),
    .tick_o    (tick)
  );

  assign expire    = tick & (count_q == 8'd0);
  assign int_req_o = exp_q & ctrl_q.ie;
  assign exp_clr   = (wr_status & port_dat_i[STATUS_EXP_BIT]) | (int_ack_i & int_req_o);

  always_comb begin
    rdata = 8'h00;
    case (ofs)
      OFS_CTRL:     rdata = {5'd0, ctrl_q};
      OFS_STATUS:   rdata = {7'd0, exp_q};
      OFS_RELOAD:   rdata = reload_q;
      OFS_COUNT:    rdata = count_q;
      OFS_PRESCALE: rdata = prescale_q;
      default:      rdata = 8'h00;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      port_ack_o  <= 1'b0;
      port_dat_o  <= 8'h00;
      xfer_hold_q <= 1'b0;
      ctrl_q      <= '0;
      exp_q       <= 1'b0;
      reload_q    <= 8'h00;
      count_q     <= 8'h00;
      prescale_q  <= 8'h00;
    end else begin
      port_ack_o  <= req;
      port_dat_o  <= rd ? rdata : 8'h00;
      xfer_hold_q <= cyc_stb & (xfer_hold_q | req);

      // A new expiry beats any clear in the same cycle.
      exp_q <= expire | (exp_q & ~exp_clr);

      if (wr_reload)   reload_q   <= port_dat_i;
      if (wr_prescale) prescale_q <= port_dat_i;

      // A RELOAD write overrides the tick's decrement or auto-reload.
      if (wr_reload) begin
        count_q <= port_dat_i;
      end else if (tick) begin
        if (count_q != 8'd0)       count_q <= count_q - 8'd1;
        else if (ctrl_q.auto_mode) count_q <= reload_q;
      end

      // An explicit CTRL write wins over the one-shot EN clear.
      if (wr_ctrl) begin
        ctrl_q <= ctrl_t'(port_dat_i[2:0]);
      end else if (expire && !ctrl_q.auto_mode) begin
        ctrl_q.en <= 1'b0;
      end
    end
  end

endmodule

// File: doc/gumnut_port_timer.md
# gumnut_port_timer

Programmable interval timer that responds on the Gumnut I/O port bus and drives the core's interrupt request line. It decodes a 5-register window at a parameterised port base address, answers port reads and writes with a registered single-cycle acknowledge, and raises `int_req` on expiry until the core returns `int_ack`. It is the first port-bus responder instantiated alongside the CPU-with-memory top level.

## Interface
- `BASE_ADDR`, default 8'h10: first port address of the register window; must be 8-aligned.
- `clk_i`  in  1  single system clock, rising-edge.
- `rst_ni`  in  1  asynchronous, active-low reset.
- `port_cyc_i`  in  1  bus cycle active.
- `port_stb_i`  in  1  strobe for this transfer.
- `port_we_i`  in  1  1 = write, 0 = read.
- `port_adr_i`  in  8  port address.
- `port_dat_i`  in  8  write data.
- `port_ack_o`  out  1  transfer acknowledge.
- `port_dat_o`  out  8  read data; 8'h00 whenever `port_ack_o` is low, so it can be OR-combined with other responders.
- `int_req_o`  out  1  interrupt request to the core.
- `int_ack_i`  in  1  interrupt taken, one-cycle pulse from the core.

## Operation
- Register map (offset from `BASE_ADDR`):
  - +0 CTRL (RW): bit0 EN, bit1 IE, bit2 AUTO; other bits read 0.
  - +1 STATUS: bit0 EXP. Write 1 to clear it; writing 0 has no effect.
  - +2 RELOAD (RW).
  - +3 COUNT (RO): writes are acknowledged and ignored.
  - +4 PRESCALE (RW).
- Offsets +5..+7 are in the window but unmapped: they acknowledge, read 8'h00, and ignore writes. Addresses outside `BASE_ADDR`..`BASE_ADDR`+7 are never acknowledged.
- Prescaler: an 8-bit down-counter that emits a one-cycle tick every PRESCALE+1 clocks while EN=1, and holds while EN=0.
- On each tick with EN=1:
  - If COUNT≠0, COUNT decrements.
  - If COUNT=0, set EXP. Then, if AUTO=1, COUNT←RELOAD; otherwise EN←0.
- Expiry period in AUTO mode is (PRESCALE+1)·(RELOAD+1) clocks.
- A RELOAD write also loads COUNT and restarts the prescaler.
- A CTRL write that changes EN from 0 to 1 restarts the prescaler.
- `int_req_o` = EXP & IE, combinational from registered state.
- `int_ack_i` while `int_req_o`=1 clears EXP. When `int_req_o`=0 it is ignored.
- Simultaneous events: an expiry in the same cycle as a STATUS clear or `int_ack_i` leaves EXP=1 (expiry wins). A RELOAD write in the same cycle as a tick takes precedence over the decrement and reload.

## Timing
- Reset values: all registers 0, so EN=0, COUNT=0 and PRESCALE=0. `port_ack_o`=0, `port_dat_o`=0, `int_req_o`=0. Reset asserted mid-transfer drops `port_ack_o` immediately.
- Handshake: `port_ack_o` is registered. It goes high on the first edge where `port_cyc_i & port_stb_i` is high with an in-window address and `port_ack_o`=0. It stays high for exactly one cycle, then goes low even if the strobe is held. Every transfer has latency 1.
- A write takes effect on the same edge that raises `port_ack_o`.
- Read data is registered with `port_ack_o` and reflects register state before that edge.
- EXP set by a tick at edge N makes `int_req_o` high after edge N when IE=1.
- `int_ack_i` sampled high at edge M makes `int_req_o` low after M, unless a new expiry occurs at M.
- Prescaler wrap: after counting down to 0 it reloads PRESCALE on the same edge the tick is emitted.

## Structure
- Shared package `gumnut_port_pkg`: register offset constants (CTRL=0, STATUS=1, RELOAD=2, COUNT=3, PRESCALE=4) and CTRL/STATUS bit-index constants, for reuse by future port peripherals and by the bench.
- One sub-module, `gumnut_prescaler`:
  - Inputs: clk, reset, enable, restart, 8-bit divisor.
  - Output: one-cycle tick.
- The bus decode and all registers stay in the top module.

## Test plan
- Reset release, then read +0..+4 → each read acks 1 cycle after strobe with data 8'h00; `int_req_o`=0.
- Write PRESCALE=3, RELOAD=4, CTRL=8'h07 → `int_req_o` rises 20 clocks after the CTRL ack. Pulse `int_ack_i` → `int_req_o` low next cycle; it rises again 20 clocks after the previous expiry.
- One-shot: CTRL=8'h03, RELOAD=2, PRESCALE=0 → EXP set after 3 ticks; CTRL reads 8'h02 (EN cleared); COUNT stays 0.
- Strobe held high for 4 cycles → exactly one `port_ack_o` pulse. Address `BASE_ADDR`+8 → no ack for 10 cycles. Write to COUNT → acked, value unchanged.
- Write 8'h01 to STATUS on the same edge as an expiry → EXP remains 1 and `int_req_o` stays high.
- Assert `rst_ni` low mid-countdown and mid-transfer → all outputs 0 asynchronously; after release, registers read 0.
